// File: rtl/vrf_read_responder_if.sv
// Bundle of the read-request, bank-write, SRAM and result buses of one VRF bank responder.
// slave: the responder's view. master: requesters, bank writer and SRAM macro.
interface vrf_read_responder_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned VS_W      = 5,
  parameter int unsigned OFFSET_W  = 8,
  parameter int unsigned IDX_W     = 3
);
  logic [NUM_PORTS-1:0]          req_valid;
  logic [NUM_PORTS-1:0]          req_ready;
  logic [NUM_PORTS*VS_W-1:0]     req_vs;
  logic [NUM_PORTS*OFFSET_W-1:0] req_offset;
  logic [NUM_PORTS*2-1:0]        req_readSource;
  logic [NUM_PORTS*IDX_W-1:0]    req_instructionIndex;

  logic                  write_valid;
  logic [VS_W-1:0]       write_vs;
  logic [OFFSET_W-1:0]   write_offset;
  logic [DATA_W-1:0]     write_data;
  logic [DATA_W/8-1:0]   write_mask;

  logic                     sram_ce;
  logic                     sram_we;
  logic [VS_W+OFFSET_W-1:0] sram_addr;
  logic [DATA_W-1:0]        sram_wdata;
  logic [DATA_W/8-1:0]      sram_wmask;
  logic [DATA_W-1:0]        sram_rdata;

  logic [DATA_W-1:0]    result_data;
  logic [NUM_PORTS-1:0] result_valid;
  logic [1:0]           result_readSource;
  logic [IDX_W-1:0]     result_instructionIndex;

  modport slave (
    input  req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
    input  write_valid, write_vs, write_offset, write_data, write_mask,
    input  sram_rdata,
    output req_ready,
    output sram_ce, sram_we, sram_addr, sram_wdata, sram_wmask,
    output result_data, result_valid, result_readSource, result_instructionIndex
  );

  modport master (
    output req_valid, req_vs, req_offset, req_readSource, req_instructionIndex,
    output write_valid, write_vs, write_offset, write_data, write_mask,
    output sram_rdata,
    input  req_ready,
    input  sram_ce, sram_we, sram_addr, sram_wdata, sram_wmask,
    input  result_data, result_valid, result_readSource, result_instructionIndex
  );
endinterface

// File: rtl/vrf_read_responder.sv
// VRF bank read responder: round-robin arbitration of read requesters onto one
// single-port SRAM, bank writes take priority, read data returned 2 cycles after the fire.
// Optional macro VRF_READ_PERF_EN adds perf_conflict_cnt / perf_read_cnt outputs.
module vrf_read_responder #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned VS_W      = 5,
  parameter int unsigned OFFSET_W  = 8,
  parameter int unsigned IDX_W     = 3
) (
  input logic                clock,
  input logic                reset,
  vrf_read_responder_if.slave bus
`ifdef VRF_READ_PERF_EN
  ,
  output logic [15:0]        perf_conflict_cnt,
  output logic [15:0]        perf_read_cnt
`endif
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]     rrPtr;
  logic [PTR_W-1:0]     grantIdx;
  logic                 grantFound;
  logic [NUM_PORTS-1:0] grantOh;
  logic                 fire;

  logic [VS_W-1:0]     selVs;
  logic [OFFSET_W-1:0] selOffset;
  logic [1:0]          selSrc;
  logic [IDX_W-1:0]    selIdx;

  logic                 s1Valid;
  logic [NUM_PORTS-1:0] s1Oh;
  logic [1:0]           s1Src;
  logic [IDX_W-1:0]     s1Idx;

  logic                 s2Valid;
  logic [NUM_PORTS-1:0] s2Oh;
  logic [DATA_W-1:0]    resData;
  logic [1:0]           resSrc;
  logic [IDX_W-1:0]     resIdx;

  // Find the first valid requester at or above the RR pointer, wrapping around.
  always_comb begin
    logic [PTR_W-1:0] cand;
    grantFound = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = PTR_W'((32'(rrPtr) + k) % NUM_PORTS);
      if (!grantFound && bus.req_valid[cand]) begin
        grantFound = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Grant is suppressed by a bank write (shared SRAM port) and while reset is held.
  always_comb begin
    grantOh = '0;
    if (grantFound && !bus.write_valid && !reset) begin
      grantOh[grantIdx] = 1'b1;
    end
  end

  assign fire          = |grantOh;
  assign bus.req_ready = grantOh;

  assign selVs     = bus.req_vs[32'(grantIdx) * VS_W +: VS_W];
  assign selOffset = bus.req_offset[32'(grantIdx) * OFFSET_W +: OFFSET_W];
  assign selSrc    = bus.req_readSource[32'(grantIdx) * 2 +: 2];
  assign selIdx    = bus.req_instructionIndex[32'(grantIdx) * IDX_W +: IDX_W];

  // SRAM command: write wins, otherwise the granted read, otherwise idle.
  always_comb begin
    bus.sram_ce    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    bus.sram_wmask = '0;
    if (bus.write_valid) begin
      bus.sram_ce    = 1'b1;
      bus.sram_we    = 1'b1;
      bus.sram_addr  = {bus.write_vs, bus.write_offset};
      bus.sram_wdata = bus.write_data;
      bus.sram_wmask = bus.write_mask;
    end else if (fire) begin
      bus.sram_ce   = 1'b1;
      bus.sram_addr = {selVs, selOffset};
    end
  end

  // RR pointer update and stage1 capture of the read's tag on a fire.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrPtr   <= '0;
      s1Valid <= 1'b0;
      s1Oh    <= '0;
      s1Src   <= '0;
      s1Idx   <= '0;
    end else begin
      s1Valid <= fire;
      if (fire) begin
        rrPtr <= PTR_W'((32'(grantIdx) + 1) % NUM_PORTS);
        s1Oh  <= grantOh;
        s1Src <= selSrc;
        s1Idx <= selIdx;
      end
    end
  end

  // Stage2: latch SRAM data and tag; result fields hold their last value when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Oh    <= '0;
      resData <= '0;
      resSrc  <= '0;
      resIdx  <= '0;
    end else begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Oh    <= s1Oh;
        resData <= bus.sram_rdata;
        resSrc  <= s1Src;
        resIdx  <= s1Idx;
      end
    end
  end

  assign bus.result_valid            = s2Valid ? s2Oh : '0;
  assign bus.result_data             = resData;
  assign bus.result_readSource       = resSrc;
  assign bus.result_instructionIndex = resIdx;

`ifdef VRF_READ_PERF_EN
  // Conflict counter saturates; read counter wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_conflict_cnt <= '0;
      perf_read_cnt     <= '0;
    end else begin
      if (bus.write_valid && (|bus.req_valid) && (perf_conflict_cnt != 16'hFFFF)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 16'd1;
      end
      if (fire) begin
        perf_read_cnt <= perf_read_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
